vga_timing_gen: RTL and testbench

Generates 640x480@60 Hz VGA raster timing: horizontal/vertical pixel counters, active-low sync pulses, the active-video flag and frame/line markers. It is the producer of the DrawX/DrawY/blank interface consumed by every sprite and background renderer, and drives the hs/vs pins of the VGA DAC. Counters are registered and all outputs are glitch-free. An optional delay stage re-aligns the sync pulses with the renderers' two-stage ROM and colour-register pipeline.

---
 rtl/vga_timing_pkg.sv | 32 +++
 rtl/vga_timing_gen_sync_delay_line.sv | 42 ++++
 rtl/vga_timing_gen.sv | 150 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared types and default constants for the 640x480@60 Hz VGA raster
//   timing generator.
//   Contents:
//     coord_t            - 10-bit raster coordinate
//     *_DEF constants    - active / porch / sync widths for 640x480@60
//     H_TOTAL_DEF        - pixels per line (800)
//     V_TOTAL_DEF        - lines per frame (525)
//     in_window()        - half-open range test lo <= v < hi
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;

  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  localparam int unsigned H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // Half-open window test used for sync pulse decode.
  function automatic logic in_window(input int v, input int lo, input int hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// sync_delay_line
//   Enable-gated shift register with a loadable reset value. Each stage
//   advances only when ce_i is high, so the delay is counted in pixels,
//   not in clocks.
//   Parameters: WIDTH (bits per stage), DEPTH (number of stages, >= 1)
//   Ports:
//     clk_i      in   clock
//     rst_i      in   synchronous active-high reset
//     ce_i       in   shift enable
//     rst_val_i  in   WIDTH  value loaded into every stage on reset
//     d_i        in   WIDTH  data in
//     q_o        out  WIDTH  data delayed by DEPTH enabled cycles
module sync_delay_line #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ce_i,
  input  logic [WIDTH-1:0] rst_val_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH < 1) begin : g_depth_chk
    $error("sync_delay_line: DEPTH must be at least 1");
  end

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= rst_val_i;
    end else if (ce_i) begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   640x480@60 Hz VGA raster timing generator (geometry parameterised).
//   Produces the DrawX/DrawY/blank interface for the renderers and the
//   active-low hs/vs pins for the DAC. All outputs are registers.
//
//   Optional build macro: VGA_TIMING_PIPE_COMP_EN
//     defined   - hs/vs pass through a PIPE_DEPTH-stage, pix_ce-gated delay
//                 so they line up with the renderers' ROM + colour register.
//     undefined - hs/vs are zero-skew with DrawX/DrawY; no delay flops.
//
//   Ports:
//     vga_clk      in   pixel-domain clock
//     reset        in   synchronous active-high reset
//     pix_ce       in   pixel advance enable
//     DrawX        out  10  horizontal counter 0..H_TOTAL-1
//     DrawY        out  10  vertical counter 0..V_TOTAL-1
//     hs, vs       out  active-low syncs
//     blank        out  1 = active video
//     line_start   out  one-clock pulse when an advance lands on DrawX==0
//     frame_start  out  one-clock pulse when an advance lands on (0,0)
//     frame_count  out  8  frames started since reset (wraps)
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
  parameter int unsigned H_FP       = H_FP_DEF,
  parameter int unsigned H_SYNC     = H_SYNC_DEF,
  parameter int unsigned H_BP       = H_BP_DEF,
  parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
  parameter int unsigned V_FP       = V_FP_DEF,
  parameter int unsigned V_SYNC     = V_SYNC_DEF,
  parameter int unsigned V_BP       = V_BP_DEF,
  parameter int unsigned PIPE_DEPTH = 2
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       pix_ce,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_chk
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end
  if (PIPE_DEPTH < 1) begin : g_pipe_chk
    $error("vga_timing_gen: PIPE_DEPTH must be at least 1");
  end

  localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);

  // Decode windows kept as int so an end of exactly 1024 cannot truncate.
  localparam int HS_START = int'(H_ACTIVE + H_FP);
  localparam int HS_END   = int'(H_ACTIVE + H_FP + H_SYNC);
  localparam int VS_START = int'(V_ACTIVE + V_FP);
  localparam int VS_END   = int'(V_ACTIVE + V_FP + V_SYNC);
  localparam int H_ACT_I  = int'(H_ACTIVE);
  localparam int V_ACT_I  = int'(V_ACTIVE);

  coord_t     x_q, x_d;
  coord_t     y_q, y_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       blank_q, blank_d;
  logic       line_q, line_d;
  logic       frame_q, frame_d;
  logic [7:0] fcount_q;

  // Next counter value; sync/blank are decoded from it so the registered
  // flags describe the same pixel as the registered counters.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (pix_ce) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
    hs_d    = !in_window(int'(x_d), HS_START, HS_END);
    vs_d    = !in_window(int'(y_d), VS_START, VS_END);
    blank_d = (int'(x_d) < H_ACT_I) && (int'(y_d) < V_ACT_I);
    line_d  = pix_ce && (x_d == '0);
    frame_d = line_d && (y_d == '0);
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      x_q      <= H_LAST;
      y_q      <= V_LAST;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      blank_q  <= 1'b0;
      line_q   <= 1'b0;
      frame_q  <= 1'b0;
      fcount_q <= 8'd0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= blank_d;
      line_q  <= line_d;
      frame_q <= frame_d;
      if (frame_d) fcount_q <= fcount_q + 8'd1;
    end
  end

  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign blank       = blank_q;
  assign line_start  = line_q;
  assign frame_start = frame_q;
  assign frame_count = fcount_q;

`ifdef VGA_TIMING_PIPE_COMP_EN
  // Bit 1 = hs, bit 0 = vs; idle (deasserted) level is 1 for both.
  logic [1:0] sync_dly;

  sync_delay_line #(
    .WIDTH(2),
    .DEPTH(int'(PIPE_DEPTH))
  ) u_sync_dly (
    .clk_i    (vga_clk),
    .rst_i    (reset),
    .ce_i     (pix_ce),
    .rst_val_i(2'b11),
    .d_i      ({hs_q, vs_q}),
    .q_o      (sync_dly)
  );

  assign hs = sync_dly[1];
  assign vs = sync_dly[0];
`else
  assign hs = hs_q;
  assign vs = vs_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  logic pix_ce;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Default-geometry DUT
  logic [9:0] d_x, d_y;
  logic       d_hs, d_vs, d_blank, d_ls, d_fs;
  logic [7:0] d_fc;

  // Reduced-geometry DUT so whole frames fit in a short run
  localparam int SHA = 8, SHF = 2, SHS = 3, SHB = 2;
  localparam int SVA = 4, SVF = 1, SVS = 2, SVB = 1;
  logic [9:0] s_x, s_y;
  logic       s_hs, s_vs, s_blank, s_ls, s_fs;
  logic [7:0] s_fc;

  vga_timing_gen u_def (
    .vga_clk(clk), .reset(reset), .pix_ce(pix_ce),
    .DrawX(d_x), .DrawY(d_y), .hs(d_hs), .vs(d_vs), .blank(d_blank),
    .line_start(d_ls), .frame_start(d_fs), .frame_count(d_fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .PIPE_DEPTH(2)
  ) u_small (
    .vga_clk(clk), .reset(reset), .pix_ce(pix_ce),
    .DrawX(s_x), .DrawY(s_y), .hs(s_hs), .vs(s_vs), .blank(s_blank),
    .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       blank;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
    logic [1:0] hd;
    logic [1:0] vd;
  } model_t;

  model_t md, ms;

  function automatic model_t model_step(input model_t s, input int ha, input int hf,
                                        input int hsy, input int hb, input int va,
                                        input int vf, input int vsy, input int vb,
                                        input logic ce, input logic rst);
    model_t n;
    int ht, vt;
    n  = s;
    ht = ha + hf + hsy + hb;
    vt = va + vf + vsy + vb;
    if (rst) begin
      n.x = 10'(ht - 1);
      n.y = 10'(vt - 1);
      n.hs = 1'b1; n.vs = 1'b1; n.blank = 1'b0;
      n.ls = 1'b0; n.fs = 1'b0; n.fc = 8'd0;
      n.hd = 2'b11; n.vd = 2'b11;
    end else if (ce) begin
      n.hd = {s.hd[0], s.hs};
      n.vd = {s.vd[0], s.vs};
      if (int'(s.x) == ht - 1) begin
        n.x = 10'd0;
        n.y = (int'(s.y) == vt - 1) ? 10'd0 : s.y + 10'd1;
      end else begin
        n.x = s.x + 10'd1;
      end
      n.ls = (n.x == 10'd0);
      n.fs = (n.x == 10'd0) && (n.y == 10'd0);
      if (n.fs) n.fc = s.fc + 8'd1;
      n.hs = !((int'(n.x) >= ha + hf) && (int'(n.x) < ha + hf + hsy));
      n.vs = !((int'(n.y) >= va + vf) && (int'(n.y) < va + vf + vsy));
      n.blank = (int'(n.x) < ha) && (int'(n.y) < va);
    end else begin
      n.ls = 1'b0;
      n.fs = 1'b0;
    end
    return n;
  endfunction

  function automatic logic [32:0] pack(input model_t s);
    logic h, v;
`ifdef VGA_TIMING_PIPE_COMP_EN
    h = s.hd[1];
    v = s.vd[1];
`else
    h = s.hs;
    v = s.vs;
`endif
    return {s.x, s.y, h, v, s.blank, s.ls, s.fs, s.fc};
  endfunction

  // ---------------- scoreboard ----------------
  localparam int W = 66;
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
    end
  endtask

  task automatic sb_compare();
    logic [W-1:0] e;
    logic [32:0]  g_def, g_small;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_empty cyc=%0d got=empty exp=entry", cyc);
      return;
    end
    e       = exp_q.pop_front();
    g_def   = {d_x, d_y, d_hs, d_vs, d_blank, d_ls, d_fs, d_fc};
    g_small = {s_x, s_y, s_hs, s_vs, s_blank, s_ls, s_fs, s_fc};
    n_checks++;
    if (g_def !== e[65:33]) begin
      n_fail++;
      $display("FAIL sb_def cyc=%0d got=%h exp=%h", cyc, g_def, e[65:33]);
    end
    n_checks++;
    if (g_small !== e[32:0]) begin
      n_fail++;
      $display("FAIL sb_small cyc=%0d got=%h exp=%h", cyc, g_small, e[32:0]);
    end
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge: drive, predict, wait one rising edge, check.
  task automatic step(input logic ce, input logic rst);
    pix_ce = ce;
    reset  = rst;
    md = model_step(md, 640, 16, 96, 48, 480, 10, 2, 33, ce, rst);
    ms = model_step(ms, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, ce, rst);
    exp_q.push_back({pack(md), pack(ms)});
    @(posedge clk);
    @(negedge clk);
    sb_compare();
    cyc++;
  endtask

  // ---------------- vector table (default geometry, line 0) ----------------
  typedef struct {
    int   x;
    logic hs;
    logic blank;
    logic ls;
  } vec_t;

  localparam int NT = 10;
  vec_t tbl[NT];

  initial begin
    #1ms;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int ti, ls_cnt, hs_low, vs_low, prev_fs, found, fs_bad;
    logic hs_comp;
`ifdef VGA_TIMING_PIPE_COMP_EN
    hs_comp = 1'b1;
`else
    hs_comp = 1'b0;
`endif
    // hs column: compensated build lags by two pixels
    tbl[0] = '{0,   1'b1,     1'b1, 1'b1};
    tbl[1] = '{639, 1'b1,     1'b1, 1'b0};
    tbl[2] = '{640, 1'b1,     1'b0, 1'b0};
    tbl[3] = '{655, 1'b1,     1'b0, 1'b0};
    tbl[4] = '{656, hs_comp,  1'b0, 1'b0};
    tbl[5] = '{658, 1'b0,     1'b0, 1'b0};
    tbl[6] = '{751, 1'b0,     1'b0, 1'b0};
    tbl[7] = '{752, !hs_comp, 1'b0, 1'b0};
    tbl[8] = '{754, 1'b1,     1'b0, 1'b0};
    tbl[9] = '{799, 1'b1,     1'b0, 1'b0};

    md = '0;
    ms = '0;
    pix_ce = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);

    chk("rst_drawx", int'(d_x), 799);
    chk("rst_drawy", int'(d_y), 524);
    chk("rst_blank", int'(d_blank), 0);

    // Phase A: free-running pix_ce, two default lines, many small frames
    ti = 0; ls_cnt = 0; hs_low = 0; vs_low = 0;
    for (int i = 0; i < 1600; i++) begin
      step(1'b1, 1'b0);
      if (i == 0) begin
        chk("first_x",  int'(d_x), 0);
        chk("first_y",  int'(d_y), 0);
        chk("first_blank", int'(d_blank), 1);
        chk("first_fs", int'(d_fs), 1);
        chk("first_fc", int'(d_fc), 1);
      end
      if (d_ls) ls_cnt++;
      if (!d_hs) hs_low++;
      if (!s_vs) vs_low++;
      if (ti < NT && d_y == 10'd0 && int'(d_x) == tbl[ti].x) begin
        chk($sformatf("tbl_hs_x%0d", tbl[ti].x), int'(d_hs), int'(tbl[ti].hs));
        chk($sformatf("tbl_blank_x%0d", tbl[ti].x), int'(d_blank), int'(tbl[ti].blank));
        chk($sformatf("tbl_ls_x%0d", tbl[ti].x), int'(d_ls), int'(tbl[ti].ls));
        ti++;
      end
    end
    chk("tbl_reached", ti, NT);
    chk("line_start_count", ls_cnt, 2);
    chk("hs_low_count", hs_low, 192);
    chk("small_vs_low_count", vs_low, 390);
    chk("small_frame_count", int'(s_fc), 14);

    // Phase B: pix_ce alternating 1/0; small frame takes 240 clocks
    step(1'b0, 1'b1);
    prev_fs = -1; fs_bad = 0;
    for (int i = 0; i < 500; i++) begin
      step((i % 2) == 0, 1'b0);
      if ((i % 2) == 1 && (s_fs || s_ls)) fs_bad++;
      if (s_fs) begin
        if (prev_fs >= 0) chk("alt_frame_period", i - prev_fs, 240);
        prev_fs = i;
      end
    end
    chk("alt_pulse_on_idle", fs_bad, 0);

    // Phase C: reset in the middle of a small-frame hsync pulse
    found = 0;
    for (int i = 0; i < 300 && found == 0; i++) begin
      step(1'b1, 1'b0);
      if (s_x == 10'd11 && s_y == 10'd2) found = 1;
    end
    chk("midrst_reached", found, 1);
`ifndef VGA_TIMING_PIPE_COMP_EN
    chk("midrst_hs_low_before", int'(s_hs), 0);
`endif
    step(1'b1, 1'b1);
    chk("midrst_hs", int'(s_hs), 1);
    chk("midrst_vs", int'(s_vs), 1);
    chk("midrst_blank", int'(s_blank), 0);
    chk("midrst_x", int'(s_x), 14);
    chk("midrst_y", int'(s_y), 7);
    chk("midrst_fc", int'(s_fc), 0);
    step(1'b1, 1'b0);
    chk("post_rst_x", int'(s_x), 0);
    chk("post_rst_fs", int'(s_fs), 1);
    chk("post_rst_fc", int'(s_fc), 1);

    chk("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
